inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Instruction fetch sequencer. It owns the program counter, reads each 16-bit instruction from the byte-wide program memory, and presents the assembled word on `inst` to the instruction register.
- It is the producer side of the `inst` interface. The control unit requests fetches and redirects the PC on jumps, using the jump target taken from the 8-bit bus.
- Big-endian: the high byte is at the even address, the low byte at the odd address.

Parameters:
- ADDR_W, 8, program-memory byte-address width. The PC is ADDR_W bits.
- RESET_PC, 0, PC value after reset. Bit 0 is forced to 0.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_req  in  1  controller requests the next instruction; level, sampled in IDLE
- jmp_en  in  1  load PC from jmp_addr
- jmp_addr  in  ADDR_W  jump target from the bus; bit 0 ignored
- mem_addr  out  ADDR_W  program-memory byte address
- mem_rd  out  1  memory read strobe; read data is valid on the cycle after the strobe
- mem_rdata  in  8  memory read data
- inst  out  16  assembled instruction; feeds the instruction register
- inst_valid  out  1  one-cycle pulse: inst updated this cycle
- busy  out  1  high whenever the state is not IDLE
- pc  out  ADDR_W  current PC: address of the next instruction to fetch

Behaviour:
- Reset, asynchronous, any state:
  - state = IDLE, pc = RESET_PC & ~1
  - inst = 16'h0000, inst_valid = 0, mem_rd = 0, mem_addr = 0, busy = 0
  - hi-byte holding register = 0
  - Reset mid-fetch abandons the fetch with no inst_valid.
- States: IDLE, RD_HI, RD_LO, DONE.
- IDLE:
  - jmp_en=1: pc <= {jmp_addr[ADDR_W-1:1],0}; stay in IDLE.
  - else fetch_req=1: go to RD_HI.
  - Both asserted: the jump wins and fetch_req is ignored that cycle.
- RD_HI: mem_addr = pc, mem_rd = 1. Go to RD_LO.
- RD_LO:
  - hi <= mem_rdata.
  - mem_addr = pc|1, mem_rd = 1.
  - Go to DONE.
- DONE:
  - inst <= {hi, mem_rdata}, inst_valid = 1 for this cycle only.
  - pc <= pc + 2, modulo 2^ADDR_W; 0xFE wraps to 0x00.
  - Go to IDLE.
- Latency: fetch_req sampled at edge N gives inst_valid high during the cycle after edge N+3. Throughput is one instruction per 4 cycles.
- jmp_en in RD_HI, RD_LO or DONE aborts the fetch:
  - pc <= jump target; state <= IDLE.
  - No inst_valid; inst keeps its old value; pc is not incremented.
- inst holds its value between pulses.
- mem_rd = 0 and mem_addr = pc whenever not reading.
- Odd PC is unreachable by construction.

Optional Feature:
- Macro: INST_FETCH_PREFETCH_EN.
- Defined: adds a one-entry prefetch buffer with a valid flag.
  - After DONE, if no jmp_en, the FSM fetches pc (already +2) into the buffer autonomously.
  - fetch_req in IDLE with the buffer valid gives inst/inst_valid on the next cycle (1-cycle latency); pc += 2 and the refill starts.
  - jmp_en flushes the buffer and any in-flight prefetch.
  - busy reflects only demand fetches.
- Undefined: the behaviour above exactly; no buffer logic.

Decomposition:
- Shared header cpu_defs.vh holds:
  - state encodings FS_IDLE/FS_RD_HI/FS_RD_LO/FS_DONE
  - INST_W=16
  - the default ADDR_W
- One natural sub-module, prog_counter: async-reset PC register with load (jump) and +2 increment, with load priority.

Test Plan:
- Reset, then memory[0..3] = 12,34,AB,CD. Two fetch_req pulses give inst = 16'h1234 then 16'hABCD, each with a single-cycle inst_valid 4 cycles after the request; pc = 0x04.
- jmp_en with jmp_addr = 0x41, then fetch gives mem_addr 0x40 then 0x41; inst = {mem[0x40],mem[0x41]}; pc = 0x42.
- jmp_en during RD_LO gives no inst_valid, inst unchanged, pc = target, state IDLE on the next cycle.
- fetch_req and jmp_en together in IDLE: the jump is taken, no memory read that cycle, busy stays 0.
- pc = 0xFE, fetch: reads 0xFE/0xFF, then pc = 0x00.
- Assert reset while in RD_HI: outputs return to reset values immediately (asynchronously); pc = 0; no inst_valid.
- With INST_FETCH_PREFETCH_EN defined: second fetch_req gives inst_valid on the next cycle; a jump then flushes, so the following fetch takes 4 cycles.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared fetch-state encodings and widths for inst_fetch
package inst_fetch_pkg;
  localparam int INST_W = 16;
  localparam int DEFAULT_ADDR_W = 8;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RD_HI = 2'd1,
    FS_RD_LO = 2'd2,
    FS_DONE  = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/prog_counter.sv
// rtl/prog_counter.sv - program counter with jump load and +2 increment (load has priority)
module prog_counter #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);
  localparam logic [ADDR_W-1:0] EVEN_MASK = ~ADDR_W'(1);

  // Instructions are 16-bit aligned, so bit 0 is always cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= RESET_PC & EVEN_MASK;
    else if (load)
      pc <= load_addr & EVEN_MASK;
    else if (inc)
      pc <= pc + ADDR_W'(2);
  end
endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - 16-bit big-endian instruction fetch sequencer over a byte-wide memory
// Optional prefetch buffer: define INST_FETCH_PREFETCH_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] pc
);
  fetch_state_e state;
  logic [7:0]   hi;
  logic         pc_inc;

`ifdef INST_FETCH_PREFETCH_EN
  logic [INST_W-1:0] buf_data;
  logic              buf_valid;
  logic              pf_active;

  assign pc_inc = (state == FS_DONE && !pf_active) ||
                  (state == FS_IDLE && fetch_req && buf_valid);
  assign busy   = (state != FS_IDLE) && !pf_active;
`else
  assign pc_inc = (state == FS_DONE);
  assign busy   = (state != FS_IDLE);
`endif

  prog_counter #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .reset     (reset),
    .load      (jmp_en),
    .load_addr (jmp_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

  // Memory port is a pure decode of state so mem_addr tracks pc while idle.
  assign mem_rd   = (state == FS_RD_HI) || (state == FS_RD_LO);
  assign mem_addr = (state == FS_RD_LO) ? (pc | ADDR_W'(1)) : pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FS_IDLE;
      hi         <= 8'h00;
      inst       <= '0;
      inst_valid <= 1'b0;
`ifdef INST_FETCH_PREFETCH_EN
      buf_data   <= '0;
      buf_valid  <= 1'b0;
      pf_active  <= 1'b0;
`endif
    end else begin
      inst_valid <= 1'b0;
      if (jmp_en) begin
        state <= FS_IDLE;
`ifdef INST_FETCH_PREFETCH_EN
        buf_valid <= 1'b0;
        pf_active <= 1'b0;
`endif
      end else begin
        case (state)
          FS_IDLE: begin
`ifdef INST_FETCH_PREFETCH_EN
            if (fetch_req && buf_valid) begin
              inst       <= buf_data;
              inst_valid <= 1'b1;
              buf_valid  <= 1'b0;
              pf_active  <= 1'b1;
              state      <= FS_RD_HI;
            end else if (fetch_req) begin
              state <= FS_RD_HI;
            end
`else
            if (fetch_req)
              state <= FS_RD_HI;
`endif
          end
          FS_RD_HI: state <= FS_RD_LO;
          FS_RD_LO: begin
            hi    <= mem_rdata;
            state <= FS_DONE;
          end
          FS_DONE: begin
`ifdef INST_FETCH_PREFETCH_EN
            // Prefetch fills the buffer without advancing pc; demand fetch refills.
            if (pf_active) begin
              buf_data  <= {hi, mem_rdata};
              buf_valid <= 1'b1;
              pf_active <= 1'b0;
              state     <= FS_IDLE;
            end else begin
              inst       <= {hi, mem_rdata};
              inst_valid <= 1'b1;
              pf_active  <= 1'b1;
              state      <= FS_RD_HI;
            end
`else
            inst       <= {hi, mem_rdata};
            inst_valid <= 1'b1;
            state      <= FS_IDLE;
`endif
          end
          default: state <= FS_IDLE;
        endcase
      end
    end
  end
endmodule
